// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: a sof-marked frame of four valid samples is
// spread onto y0..y3, with per-channel update strobes and frame status pulses.
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  output logic             frame_done,
  output logic             frame_err,
  output logic             busy,
  output logic             dbg_state,
  output logic [1:0]       dbg_chan
);

  // Input handshake: din/sof are meaningful only when din_valid=1; there is no
  // back-pressure, every valid cycle is consumed (captured or discarded).

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       chan_q, chan_d;

  logic             cap;
  logic [1:0]       cap_sel;
  logic             done_d;
  logic             err_d;
  logic [3:0]       y_valid_d;

  logic [WIDTH-1:0] y_q [4];
  logic [3:0]       y_valid_q;
  logic             frame_done_q;
  logic             frame_err_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      chan_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    case (state_q)
      S_IDLE: begin
        if (din_valid && sof) begin
          state_d = S_RUN;
          chan_d  = 2'd1;
        end
      end
      S_RUN: begin
        if (din_valid) begin
          if (sof) begin
            chan_d = 2'd1;
          end else if (chan_q == 2'd3) begin
            state_d = S_IDLE;
            chan_d  = 2'd0;
          end else begin
            chan_d = chan_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        chan_d  = 2'd0;
      end
    endcase
  end

  // Output decode: which channel (if any) captures this cycle, and the pulses
  always_comb begin
    cap     = 1'b0;
    cap_sel = 2'd0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (din_valid && sof) begin
          cap     = 1'b1;
          cap_sel = 2'd0;
        end
      end
      S_RUN: begin
        if (din_valid) begin
          cap = 1'b1;
          if (sof) begin
            // A restart aborts the current frame; it never reports done.
            cap_sel = 2'd0;
            err_d   = 1'b1;
          end else begin
            cap_sel = chan_q;
            done_d  = (chan_q == 2'd3);
          end
        end
      end
      default: begin
        cap = 1'b0;
      end
    endcase
  end

  assign y_valid_d = cap ? (4'b0001 << cap_sel) : 4'b0000;

  // Registered outputs; only the selected channel register is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        y_q[k] <= '0;
      end
      y_valid_q    <= 4'b0000;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (cap && (cap_sel == 2'(k))) begin
          y_q[k] <= din;
        end
      end
      y_valid_q    <= y_valid_d;
      frame_done_q <= done_d;
      frame_err_q  <= err_d;
    end
  end

  assign y0         = y_q[0];
  assign y1         = y_q[1];
  assign y2         = y_q[2];
  assign y3         = y_q[3];
  assign y_valid    = y_valid_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q == S_RUN);
  assign dbg_state  = state_q;
  assign dbg_chan   = chan_q;

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data width of the input sample and of each output channel.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port din, input, WIDTH bits: time-multiplexed sample.
REQ-005 SHALL have port din_valid, input, 1 bit: din carries a sample this cycle.
REQ-006 SHALL have port sof, input, 1 bit: start of frame; qualified by din_valid; marks the channel-0 sample.
REQ-007 SHALL have ports y0, y1, y2, y3, output, WIDTH bits each: registered per-channel data.
REQ-008 SHALL have port y_valid, output, 4 bits: bit k pulses high for one cycle when yk updates.
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the channel-3 sample of a frame is captured.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a sof arriving mid-frame.
REQ-011 SHALL have port busy, output, 1 bit: high while in state RUN.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and RUN, plus a 2-bit channel counter chan.
REQ-013 SHALL treat a cycle as accepted only when din_valid=1; sof with din_valid=0 is ignored.
REQ-014 SHALL, in IDLE with din_valid=1 and sof=0, discard the sample: no output changes, no pulses.
REQ-015 SHALL, in IDLE with din_valid=1 and sof=1, capture din into y0, set y_valid[0], set chan=1, and go to RUN.
REQ-016 SHALL, in RUN with din_valid=1 and sof=0, capture din into y[chan], set y_valid[chan], and increment chan.
REQ-017 SHALL, on the RUN capture with chan=3, also pulse frame_done, wrap chan to 0, and return to IDLE.
REQ-018 SHALL, in RUN with din_valid=1 and sof=1 (chan 1..3), pulse frame_err, capture din into y0 with y_valid[0], set chan=1, and stay in RUN; frame_done is not pulsed for the aborted frame.
REQ-019 SHALL, in RUN with din_valid=0, hold state, chan and all outputs; gaps of any length are allowed.
REQ-020 SHALL register all outputs; yk, y_valid, frame_done and frame_err reflect a sample one cycle after the edge that samples it (latency 1).
REQ-021 SHALL keep non-selected yk unchanged on every capture.
REQ-022 SHALL drive y_valid as one-hot or zero, with at most one bit set per cycle.
REQ-023 SHALL allow back-to-back frames: sof on the cycle after the channel-3 capture is accepted from IDLE with no bubble.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force y0..y3=0, y_valid=0, frame_done=0, frame_err=0, busy=0, chan=0, and state IDLE.
REQ-025 SHALL, on reset mid-frame, discard the partial frame, and SHALL wait for a new sof after release.

Verification
REQ-026 SHALL cover a full frame: sof+A1, 22, 33, 44 on consecutive valid cycles -> y0..y3 = A1,22,33,44; y_valid 0001,0010,0100,1000; frame_done pulses with y3 update; busy low afterwards.
REQ-027 SHALL cover gaps: the same frame with din_valid=0 for 3 cycles between each sample -> identical outputs; y_valid pulses only on capture cycles.
REQ-028 SHALL cover mid-frame sof: sof+11, 22, then sof+55, 66, 77, 88 -> frame_err one pulse at the 55 capture; final y0..y3 = 55,66,77,88; exactly one frame_done.
REQ-029 SHALL cover IDLE discard: din_valid=1, sof=0, din=FF after reset -> outputs stay 0, busy=0; sof with din_valid=0 -> ignored.
REQ-030 SHALL cover reset mid-frame: assert rst_n=0 after two samples -> all outputs 0 immediately, without waiting for a clock edge; after release, a full frame of 01..04 yields y0..y3 = 01..04.
REQ-031 SHALL cover back-to-back frames: two frames with no idle cycle between them -> two frame_done pulses 4 cycles apart; second-frame data is correct.
